// File: rtl/en_gen_pkg.sv
// Shared constants and helpers for the timebase/enable generator.
// Sizing functions are evaluated at elaboration time only.
package en_gen_pkg;

  localparam int MS_PER_S   = 1000;
  localparam int SQ_HALF_MS = 500;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/en_div_ch.sv
// One programmable divider channel clocked by the 1 ms enable.
// Holds a shadow divisor that becomes active only at the channel wrap.
module en_div_ch
  import en_gen_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             tick_o,
  output logic             sq_o
);

  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] shd_q, shd_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             tick_q;
  logic             wrap;
  logic             upd;
  logic [DIV_W:0]   half;

  always_comb begin
    shd_d = shd_q;
    div_d = div_q;
    cnt_d = cnt_q;
    sq_d  = sq_q;
    wrap  = 1'b0;
    upd   = 1'b0;
    if (we_i)
      shd_d = val_i;
    // A disabled channel has no wrap to wait for, so load at once.
    if (div_q == '0) begin
      if (we_i) begin
        div_d = val_i;
        cnt_d = '0;
        upd   = 1'b1;
      end
    end else if (en_i) begin
      upd = 1'b1;
      if (cnt_q == div_q - 1'b1) begin
        wrap  = 1'b1;
        cnt_d = '0;
        div_d = shd_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    half = ({1'b0, div_d} + 1'b1) >> 1;
    if (upd)
      sq_d = (div_d != '0) &&
             ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q  <= DEF;
      div_q  <= DEF;
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      tick_q <= wrap;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/en_gen_multi.sv
// Timebase: exact 1 ms / 1 s enables, 1 Hz square and
// N_CH programmable divider channels driven by the 1 ms enable.
module en_gen_multi
  import en_gen_pkg::*;
#(
  parameter  int CLK_HZ  = 50_000_000,
  parameter  int N_CH    = 4,
  parameter  int DIV_W   = 16,
  parameter  int DEF_DIV = 500,
  localparam int CH_W    = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             div_we,
  input  logic [CH_W-1:0]  div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick_1ms,
  output logic             tick_1s,
  output logic             sq_1hz,
  output logic [N_CH-1:0]  ch_tick,
  output logic [N_CH-1:0]  ch_sq
);

  localparam int MS_DIV = ms_div(CLK_HZ);
  localparam int PW     = clog2_min1(MS_DIV);

  localparam logic [PW-1:0] PRE_MAX = PW'(MS_DIV - 1);
  localparam logic [9:0]    MS_MAX  = 10'(MS_PER_S - 1);
  localparam logic [9:0]    MS_HALF = 10'(SQ_HALF_MS);

  if (CLK_HZ % 1000 != 0) begin : g_bad_clk
    $error("CLK_HZ must be a multiple of 1000");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("N_CH must be in 1..16");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    ms_q, ms_d;
  logic          sq_q, sq_d;
  logic          t1ms_q, t1s_q;
  logic          tc;

  assign tc = run && (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    sq_d  = sq_q;
    if (run)
      pre_d = tc ? '0 : pre_q + 1'b1;
    if (tc) begin
      ms_d = (ms_q == MS_MAX) ? '0 : ms_q + 10'd1;
      sq_d = (ms_d < MS_HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      ms_q   <= '0;
      sq_q   <= 1'b0;
      t1ms_q <= 1'b0;
      t1s_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ms_q   <= ms_d;
      sq_q   <= sq_d;
      t1ms_q <= tc;
      t1s_q  <= tc && (ms_q == MS_MAX);
    end
  end

  assign tick_1ms = t1ms_q;
  assign tick_1s  = t1s_q;
  assign sq_1hz   = sq_q;

  // Out-of-range selects match no channel and are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic we;
    assign we = div_we && (div_sel == CH_W'(g));
    en_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en_i   (tc),
      .we_i   (we),
      .val_i  (div_val),
      .tick_o (ch_tick[g]),
      .sq_o   (ch_sq[g])
    );
  end

endmodule
